// File: rtl/cpu_6502_addr_seq_pkg.sv
// Shared types for the 6502 effective-address sequencer: addressing modes,
// sequencer states, operand-byte tags and the instruction-length helper.
package cpu_6502_addr_seq_pkg;

  typedef enum logic [3:0] {
    IMPLIED           = 4'd0,
    ACCUMULATOR       = 4'd1,
    IMMEDIATE         = 4'd2,
    ZERO_PAGE         = 4'd3,
    ZERO_PAGE_X       = 4'd4,
    ZERO_PAGE_Y       = 4'd5,
    ABSOLUTE          = 4'd6,
    ABSOLUTE_X        = 4'd7,
    ABSOLUTE_Y        = 4'd8,
    INDIRECT_X        = 4'd9,
    INDIRECT_Y        = 4'd10,
    ABSOLUTE_INDIRECT = 4'd11,
    RELATIVE          = 4'd12
  } addressing_mode_t;

  typedef enum logic [2:0] {
    IDLE, OP_LO, OP_HI, PTR_LO, PTR_HI, FIX, DONE
  } addr_seq_state_t;

  // Which byte register the read returning this cycle belongs to.
  typedef enum logic [1:0] {
    BYTE_B0, BYTE_B1, BYTE_LO, BYTE_HI
  } byte_tag_t;

  localparam logic [7:0] ZP_PAGE = 8'h00;

  function automatic logic [1:0] mode_len(addressing_mode_t m);
    case (m)
      IMMEDIATE, ZERO_PAGE, ZERO_PAGE_X, ZERO_PAGE_Y,
      INDIRECT_X, INDIRECT_Y, RELATIVE:                 return 2'd2;
      ABSOLUTE, ABSOLUTE_X, ABSOLUTE_Y, ABSOLUTE_INDIRECT: return 2'd3;
      default:                                          return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/cpu_6502_ea_adder.sv
// Base + index/offset adder with low-byte carry and zero-page wrapped sum,
// shared by the indexed, indirect and relative address paths.
module cpu_6502_ea_adder #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [7:0]        offset,
  input  logic              sext,
  output logic [ADDR_W-1:0] sum,
  output logic              page_cross,
  output logic [7:0]        zp_sum
);

  logic [8:0]        lo_sum;
  logic [ADDR_W-1:0] off_ext;

  assign lo_sum  = {1'b0, base[7:0]} + {1'b0, offset};
  assign off_ext = {{(ADDR_W-8){sext & offset[7]}}, offset};
  assign sum     = base + off_ext;
  assign zp_sum  = lo_sum[7:0];
  // A signed offset can cross downwards without a carry, so compare pages.
  assign page_cross = sext ? (sum[15:8] != base[15:8]) : lo_sum[8];

endmodule

// File: rtl/cpu_6502_addr_seq.sv
// Multi-cycle 6502 effective-address sequencer. Bytes arrive one cycle after
// their read is accepted and are used combinationally in that cycle, then held.
module cpu_6502_addr_seq
  import cpu_6502_addr_seq_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter bit JMP_IND_BUG  = 1'b1,
  parameter bit PAGE_PENALTY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  addressing_mode_t  mode,
  input  logic              is_write,
  input  logic [ADDR_W-1:0] pc,
  input  logic [7:0]        x_reg,
  input  logic [7:0]        y_reg,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ea_valid,
  input  logic              ea_ready,
  output logic [ADDR_W-1:0] ea,
  output logic              ea_page_cross,
  output logic [1:0]        ea_len,
  output addr_seq_state_t   dbg_state
);

  // Handshakes: start, mem and ea each transfer on valid/req & ready at the
  // rising edge; a requester holds its payload stable until that transfer.

  addr_seq_state_t  state_q, state_d, final_state;
  addressing_mode_t mode_q;
  logic             is_write_q, pend_q, fix_needed;
  logic [ADDR_W-1:0] pc_q, ptr_lo_addr, ptr_hi_addr, ea_calc;
  logic [ADDR_W-1:0] add_base, add_sum;
  logic [7:0]        x_q, y_q, b0_q, b1_q, lo_q, hi_q;
  logic [7:0]        b0, b1, lo, hi, add_off, add_zp, idx;
  logic              add_sext, add_cross, pc_calc;
  byte_tag_t         tag_q, tag_d;

  always_comb begin
    b0 = b0_q;
    b1 = b1_q;
    lo = lo_q;
    hi = hi_q;
    if (pend_q) begin
      case (tag_q)
        BYTE_B0: b0 = mem_rdata;
        BYTE_B1: b1 = mem_rdata;
        BYTE_LO: lo = mem_rdata;
        default: hi = mem_rdata;
      endcase
    end
  end

  assign idx = (mode_q == ZERO_PAGE_X || mode_q == ABSOLUTE_X ||
                mode_q == INDIRECT_X) ? x_q : y_q;

  always_comb begin
    add_base = '0;
    add_off  = 8'h00;
    add_sext = 1'b0;
    case (mode_q)
      ZERO_PAGE_X, ZERO_PAGE_Y, INDIRECT_X: begin
        add_base = ADDR_W'({ZP_PAGE, b0});
        add_off  = idx;
      end
      ABSOLUTE_X, ABSOLUTE_Y: begin
        add_base = ADDR_W'({b1, b0});
        add_off  = idx;
      end
      INDIRECT_Y: begin
        add_base = ADDR_W'({hi, lo});
        add_off  = y_q;
      end
      RELATIVE: begin
        add_base = pc_q + ADDR_W'(2);
        add_off  = b0;
        add_sext = 1'b1;
      end
      default: ;
    endcase
  end

  cpu_6502_ea_adder #(.ADDR_W(ADDR_W)) u_ea_adder (
    .base       (add_base),
    .offset     (add_off),
    .sext       (add_sext),
    .sum        (add_sum),
    .page_cross (add_cross),
    .zp_sum     (add_zp)
  );

  always_comb begin
    ptr_lo_addr = ADDR_W'({b1, b0});
    ptr_hi_addr = JMP_IND_BUG ? ADDR_W'({b1, 8'(b0 + 8'd1)})
                              : ADDR_W'({b1, b0}) + ADDR_W'(1);
    case (mode_q)
      INDIRECT_X: begin
        ptr_lo_addr = ADDR_W'({ZP_PAGE, add_zp});
        ptr_hi_addr = ADDR_W'({ZP_PAGE, 8'(add_zp + 8'd1)});
      end
      INDIRECT_Y: begin
        ptr_lo_addr = ADDR_W'({ZP_PAGE, b0});
        ptr_hi_addr = ADDR_W'({ZP_PAGE, 8'(b0 + 8'd1)});
      end
      default: ;
    endcase
  end

  always_comb begin
    ea_calc = '0;
    pc_calc = 1'b0;
    case (mode_q)
      IMMEDIATE:                 ea_calc = pc_q + ADDR_W'(1);
      ZERO_PAGE:                 ea_calc = ADDR_W'({ZP_PAGE, b0});
      ZERO_PAGE_X, ZERO_PAGE_Y:  ea_calc = ADDR_W'({ZP_PAGE, add_zp});
      ABSOLUTE:                  ea_calc = ADDR_W'({b1, b0});
      INDIRECT_X, ABSOLUTE_INDIRECT: ea_calc = ADDR_W'({hi, lo});
      ABSOLUTE_X, ABSOLUTE_Y, INDIRECT_Y, RELATIVE: begin
        ea_calc = add_sum;
        pc_calc = add_cross;
      end
      default: ;
    endcase
  end

  // The low-byte carry is known when the last read is accepted; the branch
  // offset is not, so branch penalties stay with the execute stage.
  assign fix_needed = PAGE_PENALTY &&
                      (mode_q == ABSOLUTE_X || mode_q == ABSOLUTE_Y ||
                       mode_q == INDIRECT_Y) && (is_write_q || add_cross);
  assign final_state = fix_needed ? FIX : DONE;

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_addr = '0;
    tag_d    = BYTE_HI;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          case (mode)
            ZERO_PAGE, ZERO_PAGE_X, ZERO_PAGE_Y, ABSOLUTE, ABSOLUTE_X,
            ABSOLUTE_Y, INDIRECT_X, INDIRECT_Y, ABSOLUTE_INDIRECT,
            RELATIVE: state_d = OP_LO;
            default:  state_d = DONE;
          endcase
        end
      end
      OP_LO: begin
        mem_req  = 1'b1;
        mem_addr = pc_q + ADDR_W'(1);
        tag_d    = BYTE_B0;
        if (mem_ready) begin
          case (mode_q)
            ABSOLUTE, ABSOLUTE_X, ABSOLUTE_Y,
            ABSOLUTE_INDIRECT:      state_d = OP_HI;
            INDIRECT_X, INDIRECT_Y: state_d = PTR_LO;
            default:                state_d = final_state;
          endcase
        end
      end
      OP_HI: begin
        mem_req  = 1'b1;
        mem_addr = pc_q + ADDR_W'(2);
        tag_d    = BYTE_B1;
        if (mem_ready)
          state_d = (mode_q == ABSOLUTE_INDIRECT) ? PTR_LO : final_state;
      end
      PTR_LO: begin
        mem_req  = 1'b1;
        mem_addr = ptr_lo_addr;
        tag_d    = BYTE_LO;
        if (mem_ready) state_d = PTR_HI;
      end
      PTR_HI: begin
        mem_req  = 1'b1;
        mem_addr = ptr_hi_addr;
        if (mem_ready) state_d = final_state;
      end
      FIX:     state_d = DONE;
      DONE:    if (ea_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= IMPLIED;
      is_write_q <= 1'b0;
      pc_q       <= '0;
      x_q        <= 8'h00;
      y_q        <= 8'h00;
      b0_q       <= 8'h00;
      b1_q       <= 8'h00;
      lo_q       <= 8'h00;
      hi_q       <= 8'h00;
      pend_q     <= 1'b0;
      tag_q      <= BYTE_B0;
    end else begin
      state_q <= state_d;
      pend_q  <= mem_req & mem_ready & ~flush;
      tag_q   <= tag_d;
      if (start_valid && start_ready && !flush) begin
        mode_q     <= mode;
        is_write_q <= is_write;
        pc_q       <= pc;
        x_q        <= x_reg;
        y_q        <= y_reg;
      end
      if (pend_q && !flush) begin
        b0_q <= b0;
        b1_q <= b1;
        lo_q <= lo;
        hi_q <= hi;
      end
    end
  end

  assign start_ready   = (state_q == IDLE);
  assign ea_valid      = (state_q == DONE);
  assign ea            = ea_valid ? ea_calc : '0;
  assign ea_page_cross = ea_valid & pc_calc;
  assign ea_len        = ea_valid ? mode_len(mode_q) : 2'd0;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_cpu_6502_addr_seq.sv
// Directed bench for cpu_6502_addr_seq: byte memory model, per-mode vectors
// with hand-computed EA/flags/latency, handshake stress, flush and reset.
module tb_cpu_6502_addr_seq;
  import cpu_6502_addr_seq_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_valid = 1'b0, start_valid_b = 1'b0;
  logic             start_ready, start_ready_b;
  addressing_mode_t mode = IMPLIED;
  logic             is_write = 1'b0;
  logic [15:0]      pc = 16'h0;
  logic [7:0]       x_reg = 8'h0, y_reg = 8'h0;
  logic             flush = 1'b0;
  logic             mem_req, mem_req_b;
  logic [15:0]      mem_addr, mem_addr_b;
  logic             mem_ready = 1'b1;
  logic [7:0]       mem_rdata = 8'hA5, mem_rdata_b = 8'hA5;
  logic             ea_valid, ea_valid_b;
  logic             ea_ready = 1'b0, ea_ready_b = 1'b0;
  logic [15:0]      ea, ea_b;
  logic             ea_page_cross, ea_page_cross_b;
  logic [1:0]       ea_len, ea_len_b;
  addr_seq_state_t  dbg_state, dbg_state_b;

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_log [0:1023];
  int          rd_n = 0;
  logic [15:0] exp_q [$];
  logic        rdy_tog = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  cpu_6502_addr_seq u_dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .mode(mode), .is_write(is_write), .pc(pc), .x_reg(x_reg), .y_reg(y_reg),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .ea_valid(ea_valid), .ea_ready(ea_ready), .ea(ea),
    .ea_page_cross(ea_page_cross), .ea_len(ea_len), .dbg_state(dbg_state)
  );

  cpu_6502_addr_seq #(.JMP_IND_BUG(1'b0)) u_dut_nobug (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid_b), .start_ready(start_ready_b),
    .mode(mode), .is_write(is_write), .pc(pc), .x_reg(x_reg), .y_reg(y_reg),
    .flush(flush), .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata_b), .ea_valid(ea_valid_b), .ea_ready(ea_ready_b), .ea(ea_b),
    .ea_page_cross(ea_page_cross_b), .ea_len(ea_len_b), .dbg_state(dbg_state_b)
  );

  // Memory: data appears exactly one cycle after accept, filler otherwise.
  always @(posedge clk) begin
    if (mem_req && mem_ready) begin
      mem_rdata <= mem[mem_addr];
      if (rd_n < 1024) rd_log[rd_n] <= mem_addr;
      rd_n <= rd_n + 1;
    end else begin
      mem_rdata <= 8'hA5;
    end
    if (mem_req_b && mem_ready) mem_rdata_b <= mem[mem_addr_b];
    else mem_rdata_b <= 8'hA5;
  end

  always begin
    @(posedge clk);
    #2;
    mem_ready = rdy_tog ? ~mem_ready : 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_req(input logic [3:0] m, input logic w, input logic [15:0] p,
                           input logic [7:0] xx, input logic [7:0] yy);
    mode = addressing_mode_t'(m);
    is_write = w;
    pc = p;
    x_reg = xx;
    y_reg = yy;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    mode = IMPLIED;
    is_write = 1'b0;
    pc = 16'hDEAD;
    x_reg = 8'h77;
    y_reg = 8'h77;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!ea_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("ea_valid_seen", ea_valid, 1'b1);
  endtask

  task automatic release_ea();
    ea_ready = 1'b1;
    @(posedge clk);
    #1;
    ea_ready = 1'b0;
    chk("valid_drop", ea_valid, 1'b0);
    chk("ready_back", start_ready, 1'b1);
  endtask

  task automatic check_reads(input string tag, input int base);
    int i;
    chk({tag, "_nrd"}, rd_n - base, exp_q.size());
    i = 0;
    while (exp_q.size() > 0) begin
      chk({tag, "_rd"}, rd_log[base + i], exp_q.pop_front());
      i++;
    end
  endtask

  task automatic run_case(input string tag, input logic [3:0] m, input logic w,
                          input logic [15:0] p, input logic [7:0] xx, input logic [7:0] yy,
                          input logic [15:0] e_ea, input logic e_pc,
                          input logic [1:0] e_len, input int e_lat);
    int lat;
    int base;
    base = rd_n;
    chk({tag, "_start_ready"}, start_ready, 1'b1);
    start_req(m, w, p, xx, yy);
    wait_valid(lat);
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_ea"}, ea, e_ea);
    chk({tag, "_pc"}, ea_page_cross, e_pc);
    chk({tag, "_len"}, ea_len, e_len);
    chk({tag, "_busy"}, start_ready, 1'b0);
    check_reads(tag, base);
    release_ea();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_sr"}, start_ready, 1'b1);
    chk({tag, "_req"}, mem_req, 1'b0);
    chk({tag, "_ev"}, ea_valid, 1'b0);
    chk({tag, "_ea"}, ea, 16'h0);
    chk({tag, "_pcx"}, ea_page_cross, 1'b0);
    chk({tag, "_len"}, ea_len, 2'd0);
    chk({tag, "_st"}, dbg_state, IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, base;
    logic hold;
    logic [15:0] hold_addr;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    mem[16'h0201] = 8'hF0;
    exp_q.push_back(16'h0201);
    run_case("zpx", ZERO_PAGE_X, 1'b0, 16'h0200, 8'h20, 8'h00, 16'h0010, 1'b0, 2'd2, 2);

    mem[16'h0201] = 8'hFF; mem[16'h0202] = 8'h12;
    exp_q.push_back(16'h0201); exp_q.push_back(16'h0202);
    run_case("absy_cross", ABSOLUTE_Y, 1'b0, 16'h0200, 8'h00, 8'h01, 16'h1300, 1'b1, 2'd3, 4);

    mem[16'h0201] = 8'h10; mem[16'h0202] = 8'h20;
    exp_q.push_back(16'h0201); exp_q.push_back(16'h0202);
    run_case("absx_rd", ABSOLUTE_X, 1'b0, 16'h0200, 8'h05, 8'h00, 16'h2015, 1'b0, 2'd3, 3);
    exp_q.push_back(16'h0201); exp_q.push_back(16'h0202);
    run_case("absx_wr", ABSOLUTE_X, 1'b1, 16'h0200, 8'h05, 8'h00, 16'h2015, 1'b0, 2'd3, 4);

    run_case("implied", IMPLIED, 1'b0, 16'h1234, 8'h00, 8'h00, 16'h0000, 1'b0, 2'd1, 1);
    run_case("unused13", 4'd13, 1'b0, 16'h1234, 8'h00, 8'h00, 16'h0000, 1'b0, 2'd1, 1);
    run_case("imm", IMMEDIATE, 1'b0, 16'h4000, 8'h00, 8'h00, 16'h4001, 1'b0, 2'd2, 1);

    mem[16'h4001] = 8'h80;
    exp_q.push_back(16'h4001);
    run_case("zp", ZERO_PAGE, 1'b0, 16'h4000, 8'h00, 8'h00, 16'h0080, 1'b0, 2'd2, 2);
    mem[16'h4001] = 8'hFF;
    exp_q.push_back(16'h4001);
    run_case("zpy_wrap", ZERO_PAGE_Y, 1'b0, 16'h4000, 8'h00, 8'h02, 16'h0001, 1'b0, 2'd2, 2);

    mem[16'h4001] = 8'hCD; mem[16'h4002] = 8'hAB;
    exp_q.push_back(16'h4001); exp_q.push_back(16'h4002);
    run_case("abs", ABSOLUTE, 1'b0, 16'h4000, 8'h00, 8'h00, 16'hABCD, 1'b0, 2'd3, 3);

    mem[16'h0501] = 8'hF0; mem[16'h00FF] = 8'h78; mem[16'h0000] = 8'h56;
    exp_q.push_back(16'h0501); exp_q.push_back(16'h00FF); exp_q.push_back(16'h0000);
    run_case("indx", INDIRECT_X, 1'b0, 16'h0500, 8'h0F, 8'h00, 16'h5678, 1'b0, 2'd2, 4);

    mem[16'h0601] = 8'hFF; mem[16'h0602] = 8'h10;
    mem[16'h10FF] = 8'h34; mem[16'h1000] = 8'h12; mem[16'h1100] = 8'h56;
    exp_q.push_back(16'h0601); exp_q.push_back(16'h0602);
    exp_q.push_back(16'h10FF); exp_q.push_back(16'h1000);
    run_case("jmpind_bug", ABSOLUTE_INDIRECT, 1'b0, 16'h0600, 8'h00, 8'h00, 16'h1234, 1'b0, 2'd3, 5);

    // Same pointer on the carrying variant.
    mode = ABSOLUTE_INDIRECT;
    pc = 16'h0600;
    start_valid_b = 1'b1;
    @(posedge clk);
    #1;
    start_valid_b = 1'b0;
    lat = 1;
    while (!ea_valid_b && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("jmpind_nobug_lat", lat, 5);
    chk("jmpind_nobug_ea", ea_b, 16'h5634);
    chk("jmpind_nobug_len", ea_len_b, 2'd3);
    ea_ready_b = 1'b1;
    @(posedge clk);
    #1;
    ea_ready_b = 1'b0;
    chk("jmpind_nobug_done", ea_valid_b, 1'b0);

    mem[16'h0301] = 8'hFE;
    exp_q.push_back(16'h0301);
    run_case("rel_back2", RELATIVE, 1'b0, 16'h0300, 8'h00, 8'h00, 16'h0300, 1'b0, 2'd2, 2);
    mem[16'h0301] = 8'hFB;
    exp_q.push_back(16'h0301);
    run_case("rel_cross", RELATIVE, 1'b0, 16'h0300, 8'h00, 8'h00, 16'h02FD, 1'b1, 2'd2, 2);

    // LDA ($FF),Y under a toggling mem_ready and a slow consumer.
    mem[16'h0701] = 8'hFF; mem[16'h00FF] = 8'hF0; mem[16'h0000] = 8'h20;
    rdy_tog = 1'b1;
    base = rd_n;
    start_req(INDIRECT_Y, 1'b0, 16'h0700, 8'h00, 8'h20);
    hold = 1'b0;
    hold_addr = 16'h0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (hold && mem_req) chk("indy_addr_hold", mem_addr, hold_addr);
      hold = mem_req && !mem_ready;
      hold_addr = mem_addr;
      if (ea_valid) break;
    end
    chk("indy_valid", ea_valid, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("indy_hold_valid", ea_valid, 1'b1);
      chk("indy_hold_ea", ea, 16'h2110);
    end
    chk("indy_pc", ea_page_cross, 1'b1);
    chk("indy_len", ea_len, 2'd2);
    exp_q.push_back(16'h0701); exp_q.push_back(16'h00FF); exp_q.push_back(16'h0000);
    check_reads("indy", base);
    release_ea();
    rdy_tog = 1'b0;
    @(posedge clk);
    #1;

    // Reset in PTR_HI.
    start_req(INDIRECT_X, 1'b0, 16'h0500, 8'h0F, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid_state", dbg_state, PTR_HI);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("rst_mid_no_valid", ea_valid, 1'b0);
      chk("rst_mid_no_req", mem_req, 1'b0);
    end

    // Flush in OP_HI: the read accepted alongside it is dropped.
    start_req(ABSOLUTE, 1'b0, 16'h4000, 8'h00, 8'h00);
    @(posedge clk); #1;
    chk("flush_state", dbg_state, OP_HI);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk_reset_outs("flush_ophi");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("flush_no_valid", ea_valid, 1'b0);
    end

    // Flush while holding a result.
    start_req(IMPLIED, 1'b0, 16'h0000, 8'h00, 8'h00);
    chk("flush_done_pre", ea_valid, 1'b1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_done_ev", ea_valid, 1'b0);
    chk("flush_done_sr", start_ready, 1'b1);

    // Flush together with a start in IDLE drops the start.
    mode = ABSOLUTE;
    start_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    flush = 1'b0;
    chk_reset_outs("flush_start");

    mem[16'h4001] = 8'h3C;
    exp_q.push_back(16'h4001);
    run_case("post_flush_zp", ZERO_PAGE, 1'b0, 16'h4000, 8'h00, 8'h00, 16'h003C, 1'b0, 2'd2, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
